// File: rtl/quant_stream_packer.sv
// Multi-lane activation quantizer: per-lane round/shift/clip to INT8, INT4 or binary,
// dense packing into LANES*8-bit words, and a saturating clip-event counter.
module quant_stream_packer #(
    parameter int IN_W  = 16,
    parameter int LANES = 4,
    parameter int SAT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    input  logic [1:0]            mode,
    input  logic [4:0]            shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*8-1:0]    out_data,
    output logic                  out_last,
    output logic [SAT_W-1:0]      sat_count,
    input  logic                  sat_clr
);
    localparam int OW  = LANES * 8;
    localparam int EW  = IN_W + 32;
    localparam int CW  = $clog2(LANES + 1);
    localparam int SW1 = SAT_W + 1;

    localparam logic [1:0] MODE_INT4 = 2'd1;
    localparam logic [1:0] MODE_BIN  = 2'd2;

    logic [LANES-1:0][7:0] lane_res;
    logic [LANES-1:0]      lane_clip;
    logic [CW-1:0]         clip_sum;

    // Per-lane magnitude rounding (half away from zero), shift and clip.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IN_W-1:0] x;
        logic            neg;
        logic [EW-1:0]   xs, mag, half, rnd;
        logic [7:0]      sval, res;
        logic            clip;

        assign x    = in_data[gi*IN_W +: IN_W];
        assign neg  = x[IN_W-1];
        assign xs   = {{32{x[IN_W-1]}}, x};
        assign mag  = neg ? (~xs + EW'(1)) : xs;
        assign half = (shift == 5'd0) ? '0 : (EW'(1) << (shift - 5'd1));
        assign rnd  = (mag + half) >> shift;
        assign sval = neg ? (8'd0 - rnd[7:0]) : rnd[7:0];

        always_comb begin
            res  = sval;
            clip = 1'b0;
            case (mode)
                MODE_BIN: begin
                    res = {7'd0, ~neg};
                end
                MODE_INT4: begin
                    if (neg ? (rnd > EW'(8)) : (rnd > EW'(7))) begin
                        res  = neg ? 8'hF8 : 8'h07;
                        clip = 1'b1;
                    end
                end
                default: begin
                    if (neg ? (rnd > EW'(128)) : (rnd > EW'(127))) begin
                        res  = neg ? 8'h80 : 8'h7F;
                        clip = 1'b1;
                    end
                end
            endcase
        end

        assign lane_res[gi]  = res;
        assign lane_clip[gi] = clip;
    end

    always_comb begin
        clip_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            clip_sum = clip_sum + CW'(lane_clip[i]);
        end
    end

    // Stage 1 registers
    logic                  ready_reg;
    logic                  s1_valid_reg;
    logic [LANES-1:0][7:0] s1_res_reg;
    logic [CW-1:0]         s1_clip_reg;
    logic                  s1_last_reg;
    logic [1:0]            s1_mode_reg;

    // Packer registers
    logic [OW-1:0]    word_reg, word_next;
    logic [2:0]       beat_idx_reg, beat_idx_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_last_reg, out_last_next;
    logic [SAT_W-1:0] sat_count_reg;

    logic          s1_advance;
    logic          in_fire;
    logic [2:0]    bpw_last;
    logic [OW-1:0] placed;
    logic [SAT_W:0] sat_sum;

    assign s1_advance = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready   = ready_reg && (!s1_valid_reg || s1_advance);
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_res_reg   <= '0;
            s1_clip_reg  <= '0;
            s1_last_reg  <= 1'b0;
            s1_mode_reg  <= 2'd0;
        end else begin
            ready_reg <= 1'b1;
            if (in_fire) begin
                s1_valid_reg <= 1'b1;
                s1_res_reg   <= lane_res;
                s1_clip_reg  <= clip_sum;
                s1_last_reg  <= in_last;
                s1_mode_reg  <= mode;
            end else if (s1_advance) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        case (s1_mode_reg)
            MODE_INT4: bpw_last = 3'd1;
            MODE_BIN:  bpw_last = 3'd7;
            default:   bpw_last = 3'd0;
        endcase
    end

    // Slot placement of the stage-1 beat at the current beat index.
    always_comb begin
        placed = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s1_mode_reg)
                MODE_INT4: placed[(int'(beat_idx_reg[0]) * LANES + i) * 4 +: 4] = s1_res_reg[i][3:0];
                MODE_BIN:  placed[int'(beat_idx_reg) * LANES + i] = s1_res_reg[i][0];
                default:   placed[i*8 +: 8] = s1_res_reg[i];
            endcase
        end
    end

    always_comb begin
        word_next      = word_reg;
        beat_idx_next  = beat_idx_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        if (s1_advance) begin
            // A completed word being handed off this cycle is replaced by a fresh one.
            word_next = (out_valid_reg ? '0 : word_reg) | placed;
            if (s1_last_reg || (beat_idx_reg == bpw_last)) begin
                out_valid_next = 1'b1;
                out_last_next  = s1_last_reg;
                beat_idx_next  = 3'd0;
            end else begin
                out_valid_next = 1'b0;
                out_last_next  = 1'b0;
                beat_idx_next  = beat_idx_reg + 3'd1;
            end
        end else if (out_valid_reg && out_ready) begin
            word_next      = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
    end

    assign sat_sum = {1'b0, sat_count_reg} + SW1'(s1_clip_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg      <= '0;
            beat_idx_reg  <= 3'd0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            sat_count_reg <= '0;
        end else begin
            word_reg      <= word_next;
            beat_idx_reg  <= beat_idx_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            if (sat_clr) begin
                sat_count_reg <= '0;
            end else if (s1_advance) begin
                sat_count_reg <= sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = word_reg;
    assign out_last  = out_last_reg;
    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_quant_stream_packer.sv
// Randomized and directed checks of quant_stream_packer against an arithmetic
// reference model of rounding, clipping, packing and clip counting.
module tb_quant_stream_packer;
    localparam int IN_W  = 16;
    localparam int LANES = 4;
    localparam int SAT_W = 6;
    localparam int OW    = LANES * 8;
    localparam int SATMAX = (1 << SAT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_data;
    logic                  in_last;
    logic [1:0]            mode;
    logic [4:0]            shift;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         out_data;
    logic                  out_last;
    logic [SAT_W-1:0]      sat_count;
    logic                  sat_clr;

    quant_stream_packer #(.IN_W(IN_W), .LANES(LANES), .SAT_W(SAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_count(sat_count), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [OW-1:0] m_word = '0;
    int            m_beats = 0;
    int            m_sat = 0;
    logic [OW-1:0] exp_data[$];
    bit            exp_last[$];

    function automatic longint lane_val(input longint x, input int md, input int sh, output bit clip);
        longint m, r, v, lo, hi;
        clip = 1'b0;
        if (md == 2) return (x >= 0) ? 1 : 0;
        m  = (x < 0) ? -x : x;
        r  = (sh == 0) ? m : ((m + (longint'(1) << (sh - 1))) >> sh);
        v  = (x < 0) ? -r : r;
        lo = (md == 1) ? -8 : -128;
        hi = (md == 1) ? 7 : 127;
        if (v < lo) begin v = lo; clip = 1'b1; end
        if (v > hi) begin v = hi; clip = 1'b1; end
        return v;
    endfunction

    task automatic model_beat(input logic [LANES*IN_W-1:0] d, input int md, input int sh, input bit last);
        int w, bpw, clips;
        logic signed [IN_W-1:0] s;
        longint x, v, tmp;
        bit c;
        w   = (md == 1) ? 4 : (md == 2) ? 1 : 8;
        bpw = (md == 1) ? 2 : (md == 2) ? 8 : 1;
        clips = 0;
        for (int i = 0; i < LANES; i++) begin
            s = d[i*IN_W +: IN_W];
            x = s;
            v = lane_val(x, md, sh, c);
            if (c) clips++;
            tmp = (v & ((longint'(1) << w) - 1)) << ((m_beats * LANES + i) * w);
            m_word = m_word | tmp[OW-1:0];
        end
        m_sat = (m_sat + clips > SATMAX) ? SATMAX : m_sat + clips;
        m_beats++;
        if (m_beats == bpw || last) begin
            exp_data.push_back(m_word);
            exp_last.push_back(last);
            m_word  = '0;
            m_beats = 0;
        end
    endtask

    // ---------------- monitor / compare ----------------
    bit            prev_hold = 0;
    bit            prev_valid = 0;
    logic [OW-1:0] held_data;
    logic          held_last;
    logic [OW-1:0] last_word;
    logic          last_lastf;
    int            words = 0;
    int            acc_cnt = 0;
    longint        accept_cyc = 0;
    longint        rise_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold  = 0;
            prev_valid = 0;
        end else begin
            if (in_valid && in_ready) begin
                model_beat(in_data, int'(mode), int'(shift), in_last);
                accept_cyc = cyc;
                acc_cnt++;
            end
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held_data);
                check("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", out_data);
                end else begin
                    check("word_data", out_data, exp_data.pop_front());
                    check("word_last", out_last, exp_last.pop_front());
                end
                last_word  = out_data;
                last_lastf = out_last;
                words++;
            end
            prev_hold  = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
            prev_valid = out_valid;
        end
    end

    // ---------------- downstream ready ----------------
    bit rand_ready = 0;
    bit force_ready = 1;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [LANES*IN_W-1:0] lanes4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [LANES*IN_W-1:0] rand_beat();
        logic [LANES*IN_W-1:0] r;
        int v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 65535));
                1: v = int'($urandom_range(0, 400)) - 200;
                2: v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(120, 140)) : -int'($urandom_range(120, 140));
                default: v = ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h7FFF;
            endcase
            r[i*IN_W +: IN_W] = 16'(v);
        end
        return r;
    endfunction

    task automatic send_beat(input logic [LANES*IN_W-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_data.size() != 0 || out_valid) && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (exp_data.size() != 0 || out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_data.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sat();
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        m_sat = 0;
    endtask

    // ---------------- main sequence ----------------
    int w0, a0;
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 2'd0; shift = 5'd0; sat_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_sat", sat_count, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // INT8 rounding and clipping, latency
        mode = 2'd0; shift = 5'd4;
        send_beat(lanes4(23, -23, 2047, -4000), 1'b0);
        wait_drain();
        check("int8_word", last_word, 32'h807FFF01);
        check("int8_latency", rise_cyc - accept_cyc, 2);
        check("int8_sat", sat_count, 2);

        // INT4 two-beat word
        clear_sat();
        check("sat_clr_idle", sat_count, 0);
        mode = 2'd1; shift = 5'd0;
        send_beat(lanes4(1, -1, 7, 9), 1'b0);
        send_beat(lanes4(-8, -9, 0, 3), 1'b0);
        wait_drain();
        check("int4_word", last_word, 32'h308877F1);
        check("int4_last", last_lastf, 1'b0);
        check("int4_sat", sat_count, 2);

        // binary, early flush by in_last
        mode = 2'd2; shift = 5'd7;
        send_beat(lanes4(5, -1, 0, -7), 1'b0);
        send_beat(lanes4(-1, -2, -3, -4), 1'b0);
        send_beat(lanes4(0, 1, 2, 3), 1'b1);
        wait_drain();
        check("bin_word", last_word, 32'h00000F05);
        check("bin_last", last_lastf, 1'b1);

        // backpressure with continuous INT8 input
        mode = 2'd0; shift = 5'd0;
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        w0 = words;
        a0 = acc_cnt;
        fork
            begin
                for (int j = 0; j < 8; j++) send_beat(rand_beat(), 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_beats_held", acc_cnt - a0, 2);
                check("bp_no_words", words - w0, 0);
                force_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_word_count", words - w0, 8);

        // boundary values
        mode = 2'd0; shift = 5'd31;
        send_beat(lanes4(-32768, 32767, 1, -1), 1'b0);
        wait_drain();
        check("shift31_word", last_word, 32'h0);
        clear_sat();
        shift = 5'd0;
        send_beat(lanes4(127, 128, -128, -129), 1'b0);
        wait_drain();
        check("int8_edge_word", last_word, 32'h80807F7F);
        check("int8_edge_sat", sat_count, 2);
        for (int j = 0; j < 20; j++) send_beat(lanes4(1000, -1000, 500, -500), 1'b0);
        wait_drain();
        check("sat_saturate", sat_count, SATMAX);
        send_beat(lanes4(1000, -1000, 500, -500), 1'b0);
        wait_drain();
        check("sat_sticky", sat_count, SATMAX);
        clear_sat();
        send_beat(lanes4(1000, -1000, 500, -500), 1'b0);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        m_sat = 0;
        wait_drain();
        check("sat_clr_priority", sat_count, 0);

        // reset in the middle of an INT4 word
        mode = 2'd1; shift = 5'd0;
        send_beat(lanes4(3, 3, 3, 3), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_sat", sat_count, '0);
        check("midrst_in_ready", in_ready, 1'b0);
        m_word = '0; m_beats = 0; m_sat = 0;
        exp_data.delete();
        exp_last.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(lanes4(1, 2, 3, 4), 1'b0);
        send_beat(lanes4(5, 6, 7, -1), 1'b0);
        wait_drain();
        check("midrst_fresh_word", last_word, 32'hF7654321);

        // randomized blocks with random downstream stalls
        rand_ready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            int n;
            clear_sat();
            mode  = 2'($urandom_range(0, 3));
            shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            n = int'($urandom_range(1, 12));
            for (int j = 0; j < n; j++) begin
                send_beat(rand_beat(), (j == n - 1));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_drain();
            check("rand_sat", sat_count, SAT_W'(m_sat));
        end
        rand_ready = 1'b0;
        force_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", exp_data.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/quant_stream_packer.md
# quant_stream_packer

Streaming, multi-lane successor to the single-value quantizer. Accepts LANES signed fixed-point activations per beat over a valid/ready handshake. Each lane is rounded half-away-from-zero, shifted by a runtime amount and clipped to INT8, INT4 or binary. Results are packed densely into LANES*8-bit words for the on-chip activation buffer, and clip events are counted for calibration.

## Interface
- IN_W, 16: input lane width, signed, 2..32.
- LANES, 4: lanes per beat, power of two, 1..16.
- SAT_W, 16: saturation counter width.
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, LANES*IN_W: lane i in bits [i*IN_W +: IN_W], signed.
- in_last, input, 1: final beat of tensor; forces word flush.
- mode, input, 2: 0 = INT8, 1 = INT4, 2 = binary, 3 = reserved (treated as INT8).
- shift, input, 5: right-shift amount, 0..31.
- out_valid, output, 1: packed word valid.
- out_ready, input, 1: downstream accepts word.
- out_data, output, LANES*8: packed word.
- out_last, output, 1: word contains the in_last beat.
- sat_count, output, SAT_W: number of lanes clipped since reset/clear, sticky at all-ones.
- sat_clr, input, 1: synchronous clear of sat_count.

## Operation
- mode and shift must be stable from the first beat of a word until that word's handshake. Changing them otherwise is undefined.
- Per lane (INT8/INT4):
  - m = |x|.
  - r = shift==0 ? m : (m + 2^(shift-1)) >> shift.
  - v = sign(x)·r.
  - Internal width IN_W+32; no intermediate overflow.
  - Example: -23, shift 4 -> -1.
- Clip:
  - INT8: [-128, 127].
  - INT4: [-8, 7].
  - A lane whose v lies outside the range is a clip event.
- Binary: bit = 1 if x >= 0, else 0. shift is ignored. Binary never clips.
- Slot width W: 8 / 4 / 1 bits. Beats per word BPW: 1 / 2 / 8.
- Beat k of a word (k = 0..BPW-1) places lane i at bits [(k*LANES + i)*W +: W], two's complement truncated to W.
- Word completes when k == BPW-1 or the beat has in_last. Unfilled slots are 0. out_last = in_last of the completing beat.
- Two-stage pipeline:
  - S1 register: lane results, clip count, last flag.
  - Packer: accumulating word, beat index, out_valid.
  - S1 advances into the packer when the packer is not holding a completed word, or that word handshakes this cycle. A new word then starts at slot 0, in the same cycle as the handshake.
  - in_ready = !s1_valid || s1_advance. This is a combinational path from out_ready.
- sat_count:
  - Adds the S1 clip count when the beat enters the packer.
  - Saturates at 2^SAT_W-1.
  - sat_clr has priority over a same-cycle increment; the result is 0.

## Timing
- Reset values: in_ready 0 while rst_n low, 1 from the first cycle after release. out_valid 0, out_data 0, out_last 0, sat_count 0. S1 and packer are empty with beat index 0.
- Latency: INT8 beat accepted at edge t -> out_valid high after edge t+2 (no backpressure).
- INT4/binary: word valid 2 cycles after the completing beat is accepted.
- Full throughput: one beat per cycle while out_ready is high. For INT8 this gives one word per cycle.
- Backpressure:
  - out_valid, out_data and out_last hold stable until out_ready.
  - Maximum 1 beat in S1 plus 1 word in the packer.
  - No beat is lost or reordered.
- Reset mid-word (rst_n low at any cycle) discards S1 and any partial or completed word. The first post-reset beat uses slot 0.

## Test plan
- INT8, shift 4, lanes {23, -23, 2047, -4000} -> out_data 0x807FFF01 at t+2, sat_count 2.
- INT4, shift 0: beat0 {1, -1, 7, 9}, beat1 {-8, -9, 0, 3} -> one word 0x308877F1, out_last 0, sat_count 2.
- Binary, 3 beats {5, -1, 0, -7}, {-1, -2, -3, -4}, {0, 1, 2, 3} with in_last on the third -> out_data 0x00000F05, out_last 1.
- INT8, continuous input, out_ready low for 5 cycles -> in_ready falls after 2 beats are held. out_data is stable throughout. After release, all words arrive in order with none lost.
- shift 31 on -32768 -> 0. shift 0 on 127/128 -> 127/127 (clip). sat_count at all-ones stays there. sat_clr together with a clip -> 0.
- INT4: one beat accepted, then rst_n pulsed low -> all outputs 0. The next two beats form a fresh word starting at slot 0.
